// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front end between the EX/MEM pipeline register and data memory.
//   Accepts one memory op per handshake (IDLE), performs the memory access for
//   one cycle (ACCESS) and presents the result for one cycle (RESP).
//
// Ports
//   clk, reset            pipeline clock, asynchronous active-high reset
//   req_valid             an op is presented this cycle
//   MemRead, MemWrite     op kind; both set is treated as a load
//   Funct3                access size / signedness (instruction bits 14:12)
//   addr, wd              byte address and store data
//   req_ready             high only while idle
//   stall                 hold the pipeline until the op reaches RESP
//   resp_valid            one-cycle completion pulse
//   rdata                 extended load result, held until the next RESP
//   misalign              misaligned-access flag, valid in RESP
//   mem_addr              word-aligned address to data memory
//   mem_wdata             lane-replicated store data
//   mem_wr                per-byte write enables, bit i writes lane i
//   mem_rdata             raw word read from data memory
//
// Configuration
//   MEM_MISALIGN_TRAP_EN  when defined, misaligned ops are suppressed (no write,
//                         rdata 0) and flagged on misalign in their RESP cycle.
//                         When undefined, misalign is tied 0 and offending low
//                         address bits are ignored.

module mem_access_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wd,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  misalign,
  output logic [31:0]           mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_wr,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [DM_ADDRESS-1:0]   r_addr;
  logic [2:0]              r_f3;
  logic [DATA_W-1:0]       r_wd;
  logic                    r_is_load;
  logic [DATA_W-1:0]       r_rdata;
  logic                    w_op;
  logic [1:0]              w_lane;
  logic                    w_trap;

  // Byte-write mask for a store; the half-word case keys on lane[1] only, so
  // an odd half address still lands on its containing half.
  function automatic logic [3:0] f_store_mask(input logic [2:0] f3,
                                              input logic [1:0] lane);
    case (f3)
      3'b000:  return 4'b0001 << lane;
      3'b001:  return 4'b0011 << {lane[1], 1'b0};
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate store data across lanes so the mask alone selects the target.
  function automatic logic [DATA_W-1:0] f_store_data(input logic [2:0]        f3,
                                                     input logic [DATA_W-1:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] f_load_extend(input logic [2:0]        f3,
                                                      input logic [1:0]        lane,
                                                      input logic [DATA_W-1:0] w);
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] s;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    s = '0;
    case (f3)
      3'b000: begin s = b; return s; end
      3'b100: return {{(DATA_W-8){1'b0}}, b};
      3'b001: begin s = h; return s; end
      3'b101: return {{(DATA_W-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;

  // Store funct3 101 is not a store size, so only loads flag it.
  function automatic logic f_misaligned(input logic       is_load,
                                        input logic [2:0] f3,
                                        input logic [1:0] lane);
    case (f3)
      3'b001:  return lane[0];
      3'b101:  return is_load & lane[0];
      3'b010:  return (lane != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  assign w_trap   = f_misaligned(r_is_load, r_f3, w_lane);
  assign misalign = r_misalign;
`else
  assign w_trap   = 1'b0;
  assign misalign = 1'b0;
`endif

  assign w_op      = req_valid & (MemRead | MemWrite);
  assign w_lane    = r_addr[1:0];
  assign stall     = w_op & (r_state != S_RESP);
  assign mem_addr  = {{(32-DM_ADDRESS){1'b0}}, r_addr[DM_ADDRESS-1:2], 2'b00};
  assign mem_wdata = f_store_data(r_f3, r_wd);
  assign rdata     = r_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // mem_wr decodes from the state register, so an asynchronous reset drops it
  // immediately and a store whose edge has not arrived is abandoned.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_wr     = 4'b0000;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_op) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (!r_is_load && !w_trap) mem_wr = f_store_mask(r_f3, w_lane);
        w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch at accept; result capture at the closing edge of ACCESS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_f3      <= '0;
      r_wd      <= '0;
      r_is_load <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (r_state == S_IDLE && w_op) begin
        r_addr    <= addr;
        r_f3      <= Funct3;
        r_wd      <= wd;
        r_is_load <= MemRead;
      end
      if (r_state == S_ACCESS)
        r_rdata <= (r_is_load && !w_trap) ? f_load_extend(r_f3, w_lane, mem_rdata) : '0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Set only across the RESP cycle of a trapped op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_misalign <= 1'b0;
    else       r_misalign <= (r_state == S_ACCESS) && w_trap;
  end
`endif

endmodule
